rom_streamer: RTL and testbench
===============================

ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 2, the ROM address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 4, the ROM word width in bits.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to stream the whole ROM; sampled only in IDLE.
REQ-006 The block SHALL have port rom_addr, output, ADDR_WIDTH, address driven to the downstream combinational ROM.
REQ-007 The block SHALL have port rom_data, input, DATA_WIDTH, word returned combinationally by the ROM for rom_addr.
REQ-008 The block SHALL have port out_data, output, DATA_WIDTH, registered word being offered.
REQ-009 The block SHALL have port out_valid, output, 1, out_data is valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts out_data this cycle.
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1, one-cycle pulse after the last word is accepted.
REQ-013 The block SHALL have port checksum, output, ADDR_WIDTH+DATA_WIDTH, unsigned sum of all words of the current/last pass.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, OFFER, DONE; all outputs registered or decoded from state only (no out_ready→out_valid combinational path).
REQ-015 IDLE: rom_addr=0, out_valid=0; start=1 at an edge SHALL move to FETCH, clear address pointer to 0 and checksum to 0.
REQ-016 FETCH: on the next edge out_data SHALL load rom_data at the current rom_addr, checksum SHALL add it (zero-extended), state SHALL go to OFFER.
REQ-017 OFFER: out_valid=1, out_data and rom_addr SHALL hold stable until an edge with out_ready=1.
REQ-018 OFFER with out_ready=1 and pointer < 2^ADDR_WIDTH-1: pointer SHALL increment, state SHALL go to FETCH, out_valid SHALL drop to 0.
REQ-019 OFFER with out_ready=1 and pointer = 2^ADDR_WIDTH-1: state SHALL go to DONE; the pointer SHALL NOT wrap to 0 before DONE.
REQ-020 DONE: done=1 for exactly one cycle, out_valid=0, then IDLE unconditionally.
REQ-021 Latency: with out_ready tied high, first out_valid SHALL rise 2 edges after start is sampled; one word every 2 cycles; done SHALL pulse 2*2^ADDR_WIDTH+1 edges after start.
REQ-022 start while busy=1 SHALL be ignored; start held high through DONE SHALL begin a new pass from IDLE on the following edge.
REQ-023 checksum SHALL never overflow (width covers 2^ADDR_WIDTH*(2^DATA_WIDTH-1)) and SHALL hold its final value in IDLE until the next accepted start.
REQ-024 out_data SHALL retain the last word in IDLE/DONE; out_ready outside OFFER SHALL have no effect.

Reset
REQ-025 reset=0 SHALL immediately, independent of clock, force IDLE, rom_addr=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0.
REQ-026 Reset asserted mid-pass SHALL abort the pass with no done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-027 ROM model 0x4,0xC,0x6,0x7, out_ready=1, pulse start -> out_data 0x4,0xC,0x6,0x7 on out_valid at edges 2,4,6,8 after start; done at edge 9; checksum=29 (0x1D).
REQ-028 Same ROM, out_ready low for 3 cycles in each OFFER -> out_valid held, out_data stable, same sequence and checksum=29, done only after 4th acceptance.
REQ-029 start pulsed again during OFFER of word 1 -> ignored; single pass, exactly one done pulse.
REQ-030 ROM all 0xF -> checksum=60 (0x3C), no overflow; start held high -> second pass starts the edge after DONE, checksum reset to 0 then re-accumulates to 60.
REQ-031 reset=0 asynchronously mid-OFFER of word 2 -> all outputs zero immediately, no done; after release and start, full pass 0x4,0xC,0x6,0x7 again.

Source files
------------

// File: rtl/rom_streamer.sv
// Streams every word of a combinational ROM out through a valid/ready port,
// one word per FETCH/OFFER pair, while accumulating a running checksum.
module rom_streamer #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    output logic [ADDR_WIDTH-1:0]            rom_addr,
    input  logic [DATA_WIDTH-1:0]            rom_data,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] checksum
);

    localparam int CW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, FETCH, OFFER, DONE} state_t;

    state_t state, state_nxt;
    logic   last;

    assign last = (rom_addr == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = OFFER;
            OFFER:   if (out_ready) state_nxt = last ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rom_addr doubles as the word pointer; it parks on the last address
    // through DONE and only returns to zero on the way back to IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rom_addr <= '0;
            out_data <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rom_addr <= '0;
                        checksum <= '0;
                    end
                end
                FETCH: begin
                    out_data <= rom_data;
                    checksum <= checksum + CW'(rom_data);
                end
                OFFER: begin
                    if (out_ready && !last) rom_addr <= rom_addr + ADDR_WIDTH'(1);
                end
                DONE:    rom_addr <= '0;
                default: ;
            endcase
        end
    end

    // Handshake outputs decode state only, so out_ready never reaches out_valid.
    assign out_valid = (state == OFFER);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_rom_streamer.sv
// Directed bench for rom_streamer: a per-edge vector table for the basic pass
// plus hand-written sequences for stalls, ignored start, back-to-back passes and reset.
module tb_rom_streamer;

    localparam int AW = 2;
    localparam int DW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic [AW+DW-1:0] checksum;

    logic [DW-1:0] rom [4];
    assign rom_data = rom[rom_addr];

    rom_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always @(negedge clock) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic          st;
        logic          rdy;
        logic          v;
        logic [DW-1:0] d;
        logic          dn;
        logic          b;
        logic [AW-1:0] a;
        logic [AW+DW-1:0] cs;
    } vec_t;

    vec_t vt [12];

    function automatic vec_t mk(input logic st, input logic rdy, input logic v,
                                input logic [DW-1:0] d, input logic dn, input logic b,
                                input logic [AW-1:0] a, input logic [AW+DW-1:0] cs);
        vec_t r;
        r.st = st; r.rdy = rdy; r.v = v; r.d = d; r.dn = dn; r.b = b; r.a = a; r.cs = cs;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 12; i++) begin
            start     = vt[i].st;
            out_ready = vt[i].rdy;
            tick();
            chk($sformatf("%s%0d_valid", tag, i), 32'(out_valid), 32'(vt[i].v));
            chk($sformatf("%s%0d_data", tag, i),  32'(out_data),  32'(vt[i].d));
            chk($sformatf("%s%0d_done", tag, i),  32'(done),      32'(vt[i].dn));
            chk($sformatf("%s%0d_busy", tag, i),  32'(busy),      32'(vt[i].b));
            chk($sformatf("%s%0d_addr", tag, i),  32'(rom_addr),  32'(vt[i].a));
            chk($sformatf("%s%0d_csum", tag, i),  32'(checksum),  32'(vt[i].cs));
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_w [4];
        int n;

        rom[0] = 4'h4; rom[1] = 4'hC; rom[2] = 4'h6; rom[3] = 4'h7;
        exp_w[0] = 4'h4; exp_w[1] = 4'hC; exp_w[2] = 4'h6; exp_w[3] = 4'h7;

        // edge-by-edge expectations for one unstalled pass, edge 1 samples start
        vt[0]  = mk(1, 1, 0, 4'h0, 0, 1, 2'd0, 6'd0);
        vt[1]  = mk(0, 1, 1, 4'h4, 0, 1, 2'd0, 6'd4);
        vt[2]  = mk(0, 1, 0, 4'h4, 0, 1, 2'd1, 6'd4);
        vt[3]  = mk(0, 1, 1, 4'hC, 0, 1, 2'd1, 6'd16);
        vt[4]  = mk(0, 1, 0, 4'hC, 0, 1, 2'd2, 6'd16);
        vt[5]  = mk(0, 1, 1, 4'h6, 0, 1, 2'd2, 6'd22);
        vt[6]  = mk(0, 1, 0, 4'h6, 0, 1, 2'd3, 6'd22);
        vt[7]  = mk(0, 1, 1, 4'h7, 0, 1, 2'd3, 6'd29);
        vt[8]  = mk(0, 1, 0, 4'h7, 1, 1, 2'd3, 6'd29);
        vt[9]  = mk(0, 1, 0, 4'h7, 0, 0, 2'd0, 6'd29);
        vt[10] = mk(0, 0, 0, 4'h7, 0, 0, 2'd0, 6'd29);
        vt[11] = mk(0, 1, 0, 4'h7, 0, 0, 2'd0, 6'd29);

        // reset state
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_addr",  32'(rom_addr), 0);
        chk("rst_data",  32'(out_data), 0);
        chk("rst_csum",  32'(checksum), 0);
        #10 reset = 1'b1;

        run_table("pass");

        // stalls: out_ready low for 3 cycles in every OFFER
        done_cnt = 0;
        start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            n = 0;
            while (out_valid !== 1'b1 && n < 4) begin tick(); n++; end
            chk($sformatf("stall_w%0d_seen", w), 32'(out_valid), 1);
            chk($sformatf("stall_w%0d_data", w), 32'(out_data), 32'(exp_w[w]));
            for (int s = 0; s < 3; s++) begin
                tick();
                chk($sformatf("stall_w%0d_hold_valid", w), 32'(out_valid), 1);
                chk($sformatf("stall_w%0d_hold_data", w), 32'(out_data), 32'(exp_w[w]));
                chk($sformatf("stall_w%0d_hold_addr", w), 32'(rom_addr), 32'(w));
                chk($sformatf("stall_w%0d_nodone", w), 32'(done), 0);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("stall_w%0d_drop", w), 32'(out_valid), 0);
        end
        chk("stall_done", 32'(done), 1);
        chk("stall_csum", 32'(checksum), 29);
        tick();
        chk("stall_idle", 32'(busy), 0);
        chk("stall_done_cnt", 32'(done_cnt), 1);

        // start during OFFER of word 1 is ignored
        done_cnt = 0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("ign_offer_w1", 32'(out_data), 32'hC);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_addr", 32'(rom_addr), 2);
        for (int k = 0; k < 12; k++) tick();
        chk("ign_idle", 32'(busy), 0);
        chk("ign_done_cnt", 32'(done_cnt), 1);
        chk("ign_csum", 32'(checksum), 29);

        // all-0xF ROM, start held high across two passes
        rom[0] = 4'hF; rom[1] = 4'hF; rom[2] = 4'hF; rom[3] = 4'hF;
        out_ready = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        chk("full_done", 32'(done), 1);
        chk("full_csum", 32'(checksum), 60);
        tick();
        chk("full_idle", 32'(busy), 0);
        chk("full_idle_csum", 32'(checksum), 60);
        tick();
        chk("full_restart_busy", 32'(busy), 1);
        chk("full_restart_csum", 32'(checksum), 0);
        chk("full_restart_addr", 32'(rom_addr), 0);
        tick();
        start = 1'b0;
        chk("full_first_csum", 32'(checksum), 15);
        for (int k = 0; k < 7; k++) tick();
        chk("full2_done", 32'(done), 1);
        chk("full2_csum", 32'(checksum), 60);
        tick();
        chk("full2_idle", 32'(busy), 0);

        // asynchronous reset during OFFER of word 2
        rom[0] = 4'h4; rom[1] = 4'hC; rom[2] = 4'h6; rom[3] = 4'h7;
        done_cnt = 0;
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("ar_pre_data", 32'(out_data), 32'h6);
        chk("ar_pre_valid", 32'(out_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_busy",  32'(busy), 0);
        chk("ar_done",  32'(done), 0);
        chk("ar_addr",  32'(rom_addr), 0);
        chk("ar_data",  32'(out_data), 0);
        chk("ar_csum",  32'(checksum), 0);
        tick(); tick();
        #3 reset = 1'b1;
        tick(); tick();
        chk("ar_wait_idle", 32'(busy), 0);
        chk("ar_no_done", 32'(done_cnt), 0);

        run_table("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
